// File: rtl/intersection_phase_arbiter.sv
// intersection_phase_arbiter
//
// Round-robin phase sequencer that shares one intersection between four
// approaches (M1, M2, MT main turn, S side). One approach at a time gets
// green, bounded by minimum/maximum green times, followed by a fixed yellow
// and an all-red clearance before the next grant.
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   req[3:0]      level vehicle requests (bit0 M1, bit1 M2, bit2 MT, bit3 S)
//   light_M1/M2/MT/S [2:0]  {red,yellow,green}, one-hot, registered
//   active_phase[1:0]       approach holding green/yellow
//   phase_valid             high while in GREEN or YELLOW
//
// Optional feature (macro EMERGENCY_PREEMPT_EN):
//   emg_req             emergency request, level
//   emg_phase[1:0]      approach to preempt to
//   While emg_req is high a green on another approach is cut short, the
//   emergency approach is granted after clearance and its green is held
//   without timing out. Preemptive grants leave the round-robin pointer alone.
module intersection_phase_arbiter #(
    parameter int MIN_GREEN = 5,
    parameter int MAX_GREEN = 15,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
`ifdef EMERGENCY_PREEMPT_EN
    input  logic       emg_req,
    input  logic [1:0] emg_phase,
`endif
    output logic [2:0] light_M1,
    output logic [2:0] light_M2,
    output logic [2:0] light_MT,
    output logic [2:0] light_S,
    output logic [1:0] active_phase,
    output logic       phase_valid
);

    typedef enum logic [1:0] {IDLE, GREEN, YELLOW, ALLRED} state_t;

    localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST    = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    state_t           state, nxt_state;
    logic [CNT_W-1:0] timer, nxt_timer;
    logic [1:0]       ptr, nxt_ptr;
    logic [1:0]       nxt_phase;

    logic             others, own, go_yellow, do_arb;
    logic             arb_valid, arb_move;
    logic [1:0]       arb_phase;
    logic             emg_preempt, emg_hold;

    // First set request bit at or above p, wrapping 3->0. The loop runs from
    // the farthest offset down so the nearest hit is the one that sticks.
    function automatic logic [1:0] rr_winner(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        rr_winner = p;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) rr_winner = idx;
        end
    endfunction

    function automatic logic [2:0] decode(input state_t s, input logic [1:0] ph,
                                          input logic [1:0] idx);
        if (ph != idx)        decode = RED;
        else if (s == GREEN)  decode = GRN;
        else if (s == YELLOW) decode = YEL;
        else                  decode = RED;
    endfunction

    always_comb begin
        others = |(req & ~(4'b0001 << active_phase));
        own    = req[active_phase];

`ifdef EMERGENCY_PREEMPT_EN
        emg_preempt = emg_req && (active_phase != emg_phase);
        emg_hold    = emg_req && (active_phase == emg_phase);
        // An emergency grant overrides both the request vector and RR order.
        if (emg_req) begin
            arb_valid = 1'b1;
            arb_phase = emg_phase;
            arb_move  = 1'b0;
        end else begin
            arb_valid = |req;
            arb_phase = rr_winner(req, ptr);
            arb_move  = 1'b1;
        end
`else
        emg_preempt = 1'b0;
        emg_hold    = 1'b0;
        arb_valid   = |req;
        arb_phase   = rr_winner(req, ptr);
        arb_move    = 1'b1;
`endif

        go_yellow = emg_preempt ||
                    (!emg_hold && others &&
                     (((timer >= MIN_LAST) && !own) || (timer == MAX_LAST)));

        nxt_state = state;
        nxt_phase = active_phase;
        nxt_timer = timer;
        nxt_ptr   = ptr;
        do_arb    = 1'b0;

        case (state)
            IDLE: begin
                nxt_timer = '0;
                do_arb    = 1'b1;
            end
            GREEN: begin
                if (go_yellow) begin
                    nxt_state = YELLOW;
                    nxt_timer = '0;
                end else if (emg_hold) begin
                    // Frozen at or above the minimum so that, once the
                    // emergency clears, a waiting approach can take over at once.
                    nxt_timer = (timer < MIN_LAST) ? MIN_LAST : timer;
                end else begin
                    nxt_timer = (timer >= MAX_LAST) ? MAX_LAST : timer + 1'b1;
                end
            end
            YELLOW: begin
                if (timer == YELLOW_LAST) begin
                    nxt_state = ALLRED;
                    nxt_timer = '0;
                end else begin
                    nxt_timer = timer + 1'b1;
                end
            end
            ALLRED: begin
                if (timer == ALLRED_LAST) begin
                    nxt_timer = '0;
                    do_arb    = 1'b1;
                end else begin
                    nxt_timer = timer + 1'b1;
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_timer = '0;
            end
        endcase

        if (do_arb) begin
            if (arb_valid) begin
                nxt_state = GREEN;
                nxt_phase = arb_phase;
                if (arb_move) nxt_ptr = arb_phase + 2'd1;
            end else begin
                nxt_state = IDLE;
            end
        end
    end

    // Lights are decoded from the next state so each registered output
    // always matches the registered state of the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            ptr          <= 2'd0;
            active_phase <= 2'd0;
            phase_valid  <= 1'b0;
            light_M1     <= RED;
            light_M2     <= RED;
            light_MT     <= RED;
            light_S      <= RED;
        end else begin
            state        <= nxt_state;
            timer        <= nxt_timer;
            ptr          <= nxt_ptr;
            active_phase <= nxt_phase;
            phase_valid  <= (nxt_state == GREEN) || (nxt_state == YELLOW);
            light_M1     <= decode(nxt_state, nxt_phase, 2'd0);
            light_M2     <= decode(nxt_state, nxt_phase, 2'd1);
            light_MT     <= decode(nxt_state, nxt_phase, 2'd2);
            light_S      <= decode(nxt_state, nxt_phase, 2'd3);
        end
    end

endmodule

// File: tb/tb_intersection_phase_arbiter.sv
// tb_intersection_phase_arbiter
//
// Directed scoreboard bench for intersection_phase_arbiter. Each step pushes
// the expected light/phase picture for the cycle it drives, clocks the DUT,
// then pops and compares the registered outputs. The one-non-red safety
// invariant is checked on every cycle. Emergency steps are included when
// EMERGENCY_PREEMPT_EN is defined.
module tb_intersection_phase_arbiter;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    typedef struct packed {
        logic [11:0] lights;
        logic [1:0]  ap;
        logic        pv;
        logic        chk_ap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'h0;
    logic [2:0] light_M1, light_M2, light_MT, light_S;
    logic [1:0] active_phase;
    logic       phase_valid;
`ifdef EMERGENCY_PREEMPT_EN
    logic       emg_req   = 1'b0;
    logic [1:0] emg_phase = 2'd0;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    intersection_phase_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
`ifdef EMERGENCY_PREEMPT_EN
        .emg_req      (emg_req),
        .emg_phase    (emg_phase),
`endif
        .light_M1     (light_M1),
        .light_M2     (light_M2),
        .light_MT     (light_MT),
        .light_S      (light_S),
        .active_phase (active_phase),
        .phase_valid  (phase_valid)
    );

    always #5 clk = ~clk;

    // Four buses {M1,M2,MT,S}, all red except approach ph showing col.
    function automatic logic [11:0] bus_pattern(input logic [1:0] ph, input logic [2:0] col);
        logic [11:0] p;
        p = {R, R, R, R};
        case (ph)
            2'd0:    p[11:9] = col;
            2'd1:    p[8:6]  = col;
            2'd2:    p[5:3]  = col;
            default: p[2:0]  = col;
        endcase
        return p;
    endfunction

    task automatic check_output(input string tag);
        exp_t        e;
        logic [11:0] obs;
        int          non_red;
        e   = sb.pop_front();
        obs = {light_M1, light_M2, light_MT, light_S};

        n_checks++;
        assert (obs === e.lights) else begin
            n_fail++;
            $error("[TB] FAIL %s lights: got %b expected %b", tag, obs, e.lights);
        end

        n_checks++;
        assert (phase_valid === e.pv) else begin
            n_fail++;
            $error("[TB] FAIL %s phase_valid: got %b expected %b", tag, phase_valid, e.pv);
        end

        if (e.chk_ap) begin
            n_checks++;
            assert (active_phase === e.ap) else begin
                n_fail++;
                $error("[TB] FAIL %s active_phase: got %0d expected %0d", tag, active_phase, e.ap);
            end
        end

        non_red = int'(light_M1 != R) + int'(light_M2 != R) +
                  int'(light_MT != R) + int'(light_S != R);
        n_checks++;
        assert (non_red <= 1 && $onehot(light_M1) && $onehot(light_M2) &&
                $onehot(light_MT) && $onehot(light_S)) else begin
            n_fail++;
            $error("[TB] FAIL %s invariant: non_red=%0d buses %b expected at most 1 one-hot",
                   tag, non_red, obs);
        end
    endtask

    // Drive rst/req for n cycles; each cycle the expected picture is queued,
    // the DUT is clocked, and the outputs are compared 1 time unit later.
    task automatic apply_stimulus(input string tag, input logic r, input logic [3:0] rq,
                                  input int n, input logic [1:0] ph, input logic [2:0] col,
                                  input logic chk_ap);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.lights = bus_pattern(ph, col);
            e.pv     = (col != R);
            e.ap     = ph;
            e.chk_ap = chk_ap;
            sb.push_back(e);
            rst = r;
            req = rq;
            @(posedge clk);
            #1;
            check_output(tag);
        end
    endtask

    initial begin
        // Reset with every request raised; M1 must win first on release.
        apply_stimulus("reset",     1'b1, 4'hF, 2, 2'd0, R, 1'b1);

        // Round robin with all four waiting: each gets a full MAX_GREEN.
        apply_stimulus("rr_m1_g",   1'b0, 4'hF, 15, 2'd0, G, 1'b1);
        apply_stimulus("rr_m1_y",   1'b0, 4'hF, 3,  2'd0, Y, 1'b1);
        apply_stimulus("rr_m1_r",   1'b0, 4'hF, 1,  2'd0, R, 1'b0);
        apply_stimulus("rr_m2_g",   1'b0, 4'hF, 15, 2'd1, G, 1'b1);
        apply_stimulus("rr_m2_y",   1'b0, 4'hF, 3,  2'd1, Y, 1'b1);
        apply_stimulus("rr_m2_r",   1'b0, 4'hF, 1,  2'd1, R, 1'b0);
        apply_stimulus("rr_mt_g",   1'b0, 4'hF, 15, 2'd2, G, 1'b1);
        apply_stimulus("rr_mt_y",   1'b0, 4'hF, 3,  2'd2, Y, 1'b1);
        apply_stimulus("rr_mt_r",   1'b0, 4'hF, 1,  2'd2, R, 1'b0);
        apply_stimulus("rr_s_g",    1'b0, 4'hF, 15, 2'd3, G, 1'b1);
        apply_stimulus("rr_s_y",    1'b0, 4'hF, 3,  2'd3, Y, 1'b1);
        apply_stimulus("rr_s_r",    1'b0, 4'hF, 1,  2'd3, R, 1'b0);
        apply_stimulus("rr_m1_g2",  1'b0, 4'hF, 15, 2'd0, G, 1'b1);

        // Reset from green, then idle with no requests.
        apply_stimulus("rst_green", 1'b1, 4'h0, 1, 2'd0, R, 1'b1);
        apply_stimulus("idle",      1'b0, 4'h0, 3, 2'd0, R, 1'b1);

        // Lone request: green holds indefinitely, never yellow.
        apply_stimulus("single",    1'b0, 4'b0001, 40, 2'd0, G, 1'b1);

        // MIN_GREEN: own request dropped after 2 green cycles.
        apply_stimulus("min_rst",   1'b1, 4'h0,    1, 2'd0, R, 1'b1);
        apply_stimulus("min_g_a",   1'b0, 4'b1001, 2, 2'd0, G, 1'b1);
        apply_stimulus("min_g_b",   1'b0, 4'b1000, 3, 2'd0, G, 1'b1);
        apply_stimulus("min_y",     1'b0, 4'b1000, 3, 2'd0, Y, 1'b1);
        apply_stimulus("min_r",     1'b0, 4'b1000, 1, 2'd0, R, 1'b0);
        apply_stimulus("min_s_g",   1'b0, 4'b1000, 5, 2'd3, G, 1'b1);

        // MAX_GREEN contention between M1 and M2, alternating.
        apply_stimulus("max_rst",   1'b1, 4'h0,    1,  2'd0, R, 1'b1);
        apply_stimulus("max_m1_g",  1'b0, 4'b0011, 15, 2'd0, G, 1'b1);
        apply_stimulus("max_m1_y",  1'b0, 4'b0011, 3,  2'd0, Y, 1'b1);
        apply_stimulus("max_m1_r",  1'b0, 4'b0011, 1,  2'd0, R, 1'b0);
        apply_stimulus("max_m2_g",  1'b0, 4'b0011, 15, 2'd1, G, 1'b1);
        apply_stimulus("max_m2_y",  1'b0, 4'b0011, 3,  2'd1, Y, 1'b1);
        apply_stimulus("max_m2_r",  1'b0, 4'b0011, 1,  2'd1, R, 1'b0);
        apply_stimulus("max_m1_g2", 1'b0, 4'b0011, 15, 2'd0, G, 1'b1);
        apply_stimulus("max_m1_y2", 1'b0, 4'b0011, 3,  2'd0, Y, 1'b1);
        apply_stimulus("max_m1_r2", 1'b0, 4'b0011, 1,  2'd0, R, 1'b0);
        apply_stimulus("max_m2_g2", 1'b0, 4'b0011, 5,  2'd1, G, 1'b1);

        // Reset on the second yellow cycle: no further yellow, pointer back to 0.
        apply_stimulus("ry_rst",    1'b1, 4'h0,    1,  2'd0, R, 1'b1);
        apply_stimulus("ry_m1_g",   1'b0, 4'b0011, 15, 2'd0, G, 1'b1);
        apply_stimulus("ry_m1_y",   1'b0, 4'b0011, 2,  2'd0, Y, 1'b1);
        apply_stimulus("ry_reset",  1'b1, 4'b0010, 1,  2'd0, R, 1'b1);
        apply_stimulus("ry_m2_g",   1'b0, 4'b0010, 6,  2'd1, G, 1'b1);

`ifdef EMERGENCY_PREEMPT_EN
        // Emergency preemption of M1 in favour of S, then normal resumption.
        apply_stimulus("emg_rst",   1'b1, 4'h0,    1,  2'd0, R, 1'b1);
        apply_stimulus("emg_m1_g",  1'b0, 4'b0001, 1,  2'd0, G, 1'b1);
        emg_req   = 1'b1;
        emg_phase = 2'd3;
        apply_stimulus("emg_m1_y",  1'b0, 4'b0001, 3,  2'd0, Y, 1'b1);
        apply_stimulus("emg_m1_r",  1'b0, 4'b0001, 1,  2'd0, R, 1'b0);
        apply_stimulus("emg_s_g",   1'b0, 4'b0001, 20, 2'd3, G, 1'b1);
        emg_req   = 1'b0;
        apply_stimulus("emg_s_y",   1'b0, 4'b0001, 3,  2'd3, Y, 1'b1);
        apply_stimulus("emg_s_r",   1'b0, 4'b0001, 1,  2'd3, R, 1'b0);
        apply_stimulus("emg_m1_g2", 1'b0, 4'b0001, 3,  2'd0, G, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
